// File: rtl/la_stream_bridge_if.sv
// -----------------------------------------------------------------------------
// la_stream_bridge_if
// Purpose : valid/ready word stream used on both sides of la_stream_bridge.
// Signals : data  [W-1:0] payload word
//           valid          producer has a word on data
//           ready          consumer takes the word when valid is also high
// Modports: master = producer (drives data/valid), slave = consumer (drives ready)
// -----------------------------------------------------------------------------
interface la_stream_bridge_if #(
  parameter int W = 8
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/la_stream_bridge.sv
// -----------------------------------------------------------------------------
// la_stream_bridge
// Purpose : bridges the caravel logic-analyzer pins to the decoder core.
//           Host -> core: toggle-strobed words go into a DEPTH-entry
//           first-word-fall-through FIFO that drives the bs stream.
//           Core -> host: pix stream words are captured into a single holding
//           register, announced by toggling host_rd_ack_o and released when
//           the host toggles host_rd_tog_i.
// Ports   : wb_clk_i, reset_n (async, active low)
//           host_data_i / host_wr_tog_i  - host word + push toggle
//           host_flush_i                 - level, empties FIFO, clears overflow
//           host_rd_tog_i                - host release toggle for held word
//           host_rd_data_o / host_rd_ack_o - held word + capture toggle
//           fifo_level_o, fifo_full_o, fifo_empty_o, overflow_o - FIFO status
//           word_cnt_o                   - accepted-push counter
//           bs  (master)                 - bitstream stream to the core
//           pix (slave)                  - pixel/status stream from the core
// Options : define LA_BRIDGE_WORD_CNT_EN to build the 16-bit accepted-word
//           counter; otherwise word_cnt_o is tied to zero.
// -----------------------------------------------------------------------------
module la_stream_bridge #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 8,
  parameter int DEPTH  = 8
) (
  input  logic                    wb_clk_i,
  input  logic                    reset_n,
  input  logic [DATA_W-1:0]       host_data_i,
  input  logic                    host_wr_tog_i,
  input  logic                    host_flush_i,
  input  logic                    host_rd_tog_i,
  output logic [OUT_W-1:0]        host_rd_data_o,
  output logic                    host_rd_ack_o,
  output logic [$clog2(DEPTH):0]  fifo_level_o,
  output logic                    fifo_full_o,
  output logic                    fifo_empty_o,
  output logic                    overflow_o,
  output logic [15:0]             word_cnt_o,
  la_stream_bridge_if.master      bs,
  la_stream_bridge_if.slave       pix
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HELD  = 1'b1;

  // armed_q stays low for the first clock after reset so the toggle shadows
  // can pick up the live input levels without firing a push or release.
  logic              armed_q, armed_d;
  logic              wr_tog_q, wr_tog_d;
  logic              rd_tog_q, rd_tog_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [0:0]        state_q, state_d;
  logic [OUT_W-1:0]  rd_data_q, rd_data_d;
  logic              ack_q, ack_d;

  logic push_req_s, rd_rel_s, pop_s, accept_s, full_s, empty_s;

  assign full_s     = (level_q == LVL_FULL);
  assign empty_s    = (level_q == {LVL_W{1'b0}});
  assign push_req_s = armed_q & (host_wr_tog_i ^ wr_tog_q);
  assign rd_rel_s   = armed_q & (host_rd_tog_i ^ rd_tog_q);

  assign bs.valid   = ~empty_s & ~host_flush_i;
  assign bs.data    = mem_q[rd_ptr_q];
  assign pop_s      = bs.valid & bs.ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign accept_s   = push_req_s & ~host_flush_i & (~full_s | pop_s);

  assign pix.ready      = (state_q == ST_EMPTY);
  assign host_rd_data_o = rd_data_q;
  assign host_rd_ack_o  = ack_q;
  assign fifo_level_o   = level_q;
  assign fifo_full_o    = full_s;
  assign fifo_empty_o   = empty_s;
  assign overflow_o     = overflow_q;

  // Toggle shadows track their inputs every cycle, including during flush.
  always_comb begin
    armed_d  = 1'b1;
    wr_tog_d = host_wr_tog_i;
    rd_tog_d = host_rd_tog_i;
  end

  // FIFO pointers, occupancy, storage and sticky overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    mem_d      = mem_q;
    if (host_flush_i) begin
      wr_ptr_d   = {PTR_W{1'b0}};
      rd_ptr_d   = {PTR_W{1'b0}};
      level_d    = {LVL_W{1'b0}};
      overflow_d = 1'b0;
    end else begin
      if (accept_s) begin
        mem_d[wr_ptr_q] = host_data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({accept_s, pop_s})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
      if (push_req_s && !accept_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end
  end

  // Capture FSM: one held word, released by the host read toggle.
  always_comb begin
    state_d   = state_q;
    rd_data_d = rd_data_q;
    ack_d     = ack_q;
    case (state_q)
      ST_EMPTY: begin
        if (pix.valid) begin
          rd_data_d = pix.data;
          ack_d     = ~ack_q;
          state_d   = ST_HELD;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_HELD: begin
        if (rd_rel_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_HELD;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State registers; reset discards FIFO contents and any held word.
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      armed_q    <= 1'b0;
      wr_tog_q   <= 1'b0;
      rd_tog_q   <= 1'b0;
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      level_q    <= {LVL_W{1'b0}};
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
      state_q    <= ST_EMPTY;
      rd_data_q  <= {OUT_W{1'b0}};
      ack_q      <= 1'b0;
    end else begin
      armed_q    <= armed_d;
      wr_tog_q   <= wr_tog_d;
      rd_tog_q   <= rd_tog_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
      state_q    <= state_d;
      rd_data_q  <= rd_data_d;
      ack_q      <= ack_d;
    end
  end

`ifdef LA_BRIDGE_WORD_CNT_EN
  logic [15:0] word_cnt_q, word_cnt_d;

  // Accepted-push counter; wraps naturally, only reset clears it.
  always_comb begin
    word_cnt_d = word_cnt_q;
    if (accept_s) begin
      word_cnt_d = word_cnt_q + 16'd1;
    end else begin
      word_cnt_d = word_cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      word_cnt_q <= 16'd0;
    end else begin
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_cnt_o = word_cnt_q;
`else
  assign word_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_la_stream_bridge.sv
// -----------------------------------------------------------------------------
// tb_la_stream_bridge
// Directed bench for la_stream_bridge (DATA_W=16, OUT_W=8, DEPTH=8).
// Pushed words go into a queue holding the expected FIFO contents; each clock
// the bench compares popped words, level and status flags against that queue.
// Honours LA_BRIDGE_WORD_CNT_EN for the expected word_cnt_o value.
// -----------------------------------------------------------------------------
module tb_la_stream_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] host_data;
  logic        wr_tog, flush, rd_tog;
  logic [7:0]  rd_data;
  logic        rd_ack;
  logic [3:0]  level;
  logic        full, empty, ovf;
  logic [15:0] word_cnt;

  la_stream_bridge_if #(.W(16)) bs_if ();
  la_stream_bridge_if #(.W(8))  pix_if ();

  la_stream_bridge #(.DATA_W(16), .OUT_W(8), .DEPTH(8)) dut (
    .wb_clk_i      (clk),
    .reset_n       (rst_n),
    .host_data_i   (host_data),
    .host_wr_tog_i (wr_tog),
    .host_flush_i  (flush),
    .host_rd_tog_i (rd_tog),
    .host_rd_data_o(rd_data),
    .host_rd_ack_o (rd_ack),
    .fifo_level_o  (level),
    .fifo_full_o   (full),
    .fifo_empty_o  (empty),
    .overflow_o    (ovf),
    .word_cnt_o    (word_cnt),
    .bs            (bs_if),
    .pix           (pix_if)
  );

  always #5 clk = ~clk;

  logic [15:0] sb[$];
  logic        ovf_m;
  logic [15:0] cnt_m;
  logic        pushed_now;
  int          checks;
  int          errors;

  function automatic logic [15:0] cnt_exp();
`ifdef LA_BRIDGE_WORD_CNT_EN
    return cnt_m;
`else
    return 16'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs were set just after the previous edge, outputs are
  // sampled 1 time unit after this edge.
  task automatic tick();
    logic        pop_m;
    logic        flushing;
    logic [15:0] head;
    int          occ_before;
    #1;
    occ_before = sb.size() - (pushed_now ? 1 : 0);
    pop_m      = (occ_before > 0) && bs_if.ready && !flush;
    flushing   = flush;
    head       = bs_if.data;
    @(posedge clk);
    #1;
    if (flushing) begin
      sb.delete();
      ovf_m = 1'b0;
    end else if (pop_m) begin
      chk("bs_data", {16'd0, head}, {16'd0, sb.pop_front()});
    end
    pushed_now = 1'b0;
    chk("level", 32'(level), 32'(sb.size()));
    chk("empty", 32'(empty), 32'(sb.size() == 0));
    chk("full", 32'(full), 32'(sb.size() == 8));
    chk("bs_valid", 32'(bs_if.valid), 32'((sb.size() != 0) && !flush));
    chk("overflow", 32'(ovf), 32'(ovf_m));
    chk("word_cnt", 32'(word_cnt), 32'(cnt_exp()));
  endtask

  task automatic push(input logic [15:0] d);
    int   occ;
    logic pop_m;
    logic acc;
    occ       = sb.size();
    pop_m     = (occ > 0) && bs_if.ready && !flush;
    acc       = !flush && ((occ < 8) || pop_m);
    host_data = d;
    wr_tog    = ~wr_tog;
    if (acc) begin
      sb.push_back(d);
      cnt_m      = cnt_m + 16'd1;
      pushed_now = 1'b1;
    end else if (!flush) begin
      ovf_m = 1'b1;
    end
    tick();
  endtask

  initial begin
    checks = 0; errors = 0;
    ovf_m = 1'b0; cnt_m = 16'd0; pushed_now = 1'b0;
    rst_n = 1'b0; host_data = 16'h0000;
    wr_tog = 1'b1; rd_tog = 1'b1; flush = 1'b0;
    bs_if.ready = 1'b0; pix_if.valid = 1'b0; pix_if.data = 8'h00;
    #12;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_valid", 32'(bs_if.valid), 32'd0);
    chk("rst_ack", 32'(rd_ack), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_pix_ready", 32'(pix_if.ready), 32'd1);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // Toggle inputs were high through reset: no push/release must fire.
    tick(); tick();
    chk("no_push_from_reset", 32'(level), 32'd0);

    // Basic ordering with ready low, then drain.
    push(16'h1111); push(16'h2222); push(16'h3333);
    chk("level3", 32'(level), 32'd3);
    chk("head1111", 32'(bs_if.data), 32'h1111);
    bs_if.ready = 1'b1;
    tick(); tick(); tick();
    chk("drained_empty", 32'(empty), 32'd1);

    // Fill to full and overflow on the ninth push.
    bs_if.ready = 1'b0;
    for (int i = 0; i < 8; i++) push(16'h0100 + 16'(i));
    chk("full_after_8", 32'(full), 32'd1);
    push(16'hBAD0);
    chk("ovf_after_9", 32'(ovf), 32'd1);
    chk("level_stays_8", 32'(level), 32'd8);

    // Flush clears overflow; then full FIFO with pop and push together.
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_ovf_clr", 32'(ovf), 32'd0);
    for (int i = 0; i < 8; i++) push(16'h0200 + 16'(i));
    bs_if.ready = 1'b1;
    push(16'hABCD);
    chk("full_pushpop_level", 32'(level), 32'd8);
    chk("full_pushpop_noovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    chk("drain_done", 32'(empty), 32'd1);
    bs_if.ready = 1'b0;

    // Fill 5, flush for one cycle with a toggle during it, no stale push.
    for (int i = 0; i < 5; i++) push(16'h0300 + 16'(i));
    flush = 1'b1;
    push(16'hDEAD);
    flush = 1'b0;
    chk("flush_level0", 32'(level), 32'd0);
    tick();
    chk("no_stale_push", 32'(level), 32'd0);
    push(16'h7777);
    chk("post_flush_level1", 32'(level), 32'd1);
    chk("post_flush_head", 32'(bs_if.data), 32'h7777);
    bs_if.ready = 1'b1;
    tick();

    // Capture path.
    pix_if.data = 8'hA5; pix_if.valid = 1'b1;
    tick();
    chk("cap_a5", 32'(rd_data), 32'hA5);
    chk("cap_ack1", 32'(rd_ack), 32'd1);
    chk("cap_ready0", 32'(pix_if.ready), 32'd0);
    pix_if.data = 8'h5A;
    tick(); tick();
    chk("held_a5", 32'(rd_data), 32'hA5);
    chk("held_ack1", 32'(rd_ack), 32'd1);
    rd_tog = ~rd_tog;
    tick();
    chk("release_ready1", 32'(pix_if.ready), 32'd1);
    chk("release_still_a5", 32'(rd_data), 32'hA5);
    tick();
    chk("cap_5a", 32'(rd_data), 32'h5A);
    chk("cap_ack0", 32'(rd_ack), 32'd0);
    chk("cap2_ready0", 32'(pix_if.ready), 32'd0);
    pix_if.valid = 1'b0;

`ifdef LA_BRIDGE_WORD_CNT_EN
    // Run the counter up to 0xFFFF, then one more push wraps it.
    for (int i = 0; i < 70000 && cnt_m != 16'hFFFF; i++) push(16'(i));
    chk("cnt_at_ffff", 32'(word_cnt), 32'hFFFF);
    push(16'h5555);
    chk("cnt_wrap", 32'(word_cnt), 32'h0000);
`else
    for (int i = 0; i < 4; i++) push(16'h0400 + 16'(i));
    chk("cnt_tied0", 32'(word_cnt), 32'h0000);
`endif
    tick(); tick();

    // Asynchronous reset mid-operation with a held word and queued data.
    rd_tog = ~rd_tog;
    tick();
    pix_if.data = 8'h3C; pix_if.valid = 1'b1;
    tick();
    pix_if.valid = 1'b0;
    chk("pre_rst_held", 32'(rd_data), 32'h3C);
    bs_if.ready = 1'b0;
    push(16'h0A0A); push(16'h0B0B);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_valid", 32'(bs_if.valid), 32'd0);
    chk("arst_rd_data", 32'(rd_data), 32'd0);
    chk("arst_ack", 32'(rd_ack), 32'd0);
    chk("arst_pix_ready", 32'(pix_if.ready), 32'd1);
    chk("arst_word_cnt", 32'(word_cnt), 32'd0);
    sb.delete(); ovf_m = 1'b0; cnt_m = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
